adc_serial_capture: RTL and testbench
=====================================

Name: adc_serial_capture

Overview:
- SPI-style master for a 12-bit serial ADC of the AD7476 type: CS low, 16 SCLK bits, 4 leading zeros, then 12 data bits MSB first.
- Produces the parallel unsigned `data_ADC` word and a 1-cycle valid strobe.
- Sits directly upstream of the ADC-to-signed truncation/offset stage, which feeds the filter chain.
- Conversions are started by a `start` request, typically the sample-rate tick.

Parameters:
- N_ADC, 12, ADC data width in bits.
- FRAME_BITS, 16, SCLK cycles per frame; leading bits = FRAME_BITS-N_ADC.
- DIV, 4, clk cycles per SCLK half-period (≥1).
- QUIET_CYC, 8, clk cycles cs_n held high after a frame before a new start is accepted (≥1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, conversion request; sampled only in IDLE.
- sdata, input, 1, ADC serial data out.
- cs_n, output, 1, ADC chip select, active low.
- sclk, output, 1, ADC serial clock; idles high.
- data_ADC, output, N_ADC, last captured sample, unsigned.
- data_valid, output, 1, 1-cycle pulse when `data_ADC` updates.
- busy, output, 1, high whenever not in IDLE.
- frame_err, output, 1, leading-bit error pulse (see Optional Feature).

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: cs_n=1, sclk=1, data_ADC=0, data_valid=0, busy=0, frame_err=0, state=IDLE, all counters 0.
- FSM is IDLE → CONV → QUIET → IDLE.
- IDLE:
  - start=1 at edge E0 → cs_n<=0, state<=CONV, half-period counter<=0, bit counter<=0.
  - busy is 1 from E0.
- CONV:
  - sclk toggles every DIV clk cycles: first fall at E0+DIV, first rise at E0+2·DIV.
  - sdata is shifted into an FRAME_BITS-wide shift register at each clk edge where sclk goes 0→1.
  - Bit k (1..FRAME_BITS) is sampled at E0+2k·DIV.
- Frame end, at the edge of sample FRAME_BITS (E0+2·FRAME_BITS·DIV):
  - cs_n<=1 and sclk stays high.
  - data_ADC<=low N_ADC bits of the shift register, with the final bit included.
  - data_valid<=1 for exactly one cycle; state<=QUIET.
- QUIET:
  - Counts QUIET_CYC cycles with cs_n=1, then returns to IDLE.
  - start is ignored throughout CONV and QUIET; requests are not queued.
- Default latency, start edge to data_valid high: 2·16·4 = 128 cycles.
- Back-to-back: start held high gives a frame period of 2·FRAME_BITS·DIV + QUIET_CYC + 1 cycles.
- data_ADC holds its value between frames. Downstream samples it on data_valid or uses the held value.
- Reset mid-frame:
  - Immediately forces cs_n=1, sclk=1, IDLE.
  - data_ADC=0; the partial frame is discarded with no data_valid.
- DIV=1: sclk=clk/2. Counter widths are sized with $clog2 of DIV and FRAME_BITS.

Optional Feature:
- Macro: ADC_LEADZERO_CHECK_EN.
- Defined: at frame end, frame_err pulses together with data_valid if any of the FRAME_BITS-N_ADC leading bits is 1. data_ADC is still updated.
- Undefined: frame_err is tied 0 and no check logic is synthesized.

Decomposition:
- Shared package/include: N_ADC, FRAME_BITS, default DIV and QUIET_CYC; the FSM state encoding (IDLE=2'd0, CONV=2'd1, QUIET=2'd2).
- One natural sub-module: sclk_divider, a half-period counter producing the sclk level plus a rise_tick strobe, enabled only in CONV.
- Shift register and FSM stay in the top module.

Test Plan:
- Basic frame: DIV=2, QUIET_CYC=8; ADC model drives 0000_1010_1011_1100 MSB first on each sclk fall → data_ADC=12'hABC with data_valid pulse at start+64; cs_n low for exactly 64 cycles.
- Back-to-back: start held high, samples 12'h000, 12'hFFF, 12'h801 → three data_valid pulses spaced 2·16·2+8+1=73 cycles, values correct in order.
- Ignored start: start pulsed at start+10 and during QUIET → no extra frame, busy stays 1, single data_valid.
- Reset mid-frame: rst_n low at start+30 → cs_n=1, sclk=1, busy=0 within the same cycle; no data_valid; next start produces a correct fresh frame.
- Leading-bit error, with ADC_LEADZERO_CHECK_EN: frame 0100_0001_0010_0011 → data_ADC=12'h123, frame_err=1 coincident with data_valid. Without the macro, frame_err stays 0.
- DIV=1 corner: frame 0000_0000_0000_0001 → data_ADC=12'h001 at start+32; sclk period 2 clk.

Source files
------------

// File: rtl/adc_serial_capture_pkg.sv
// adc_serial_capture_pkg
//   Shared constants and types for the serial ADC capture block:
//   default geometry of an AD7476-style frame, FSM state encoding and a
//   helper that sizes counters so a modulus of 1 still gets a 1-bit counter.
package adc_serial_capture_pkg;

    localparam int unsigned DEF_N_ADC      = 12;
    localparam int unsigned DEF_FRAME_BITS = 16;
    localparam int unsigned DEF_DIV        = 4;
    localparam int unsigned DEF_QUIET_CYC  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } state_t;

    // $clog2(1) is 0; never build a zero-width counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_serial_capture_sclk_divider.sv
// adc_serial_capture_sclk_divider
//   Half-period counter generating the ADC serial clock.
//   Ports:
//     clk, rst_n  - system clock, async active-low reset
//     en          - run the divider (high only while a frame is converting)
//     sclk        - serial clock level; idles high whenever en is low
//     rise_tick   - high on the clk edge at which sclk goes 0->1
module adc_serial_capture_sclk_divider
    import adc_serial_capture_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_tick
);

    localparam int unsigned HW = cnt_width(DIV);

    logic [HW-1:0] hcnt;
    logic          half_done;

    assign half_done = en && (hcnt == HW'(DIV - 1));
    assign rise_tick = half_done && !sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            sclk <= 1'b1;
        end else if (!en) begin
            hcnt <= '0;
            sclk <= 1'b1;
        end else if (half_done) begin
            hcnt <= '0;
            sclk <= ~sclk;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_serial_capture.sv
// adc_serial_capture
//   SPI-style master for a 12-bit AD7476-type ADC. A start request in IDLE
//   drops cs_n and clocks FRAME_BITS sclk cycles; sdata is shifted in on each
//   sclk rise and the low N_ADC bits are published with a one-cycle strobe.
//   cs_n is then held high for QUIET_CYC cycles before the next start.
//   Ports:
//     clk, rst_n  - system clock, async active-low reset
//     start       - conversion request, only honoured in IDLE
//     sdata       - ADC serial data
//     cs_n, sclk  - ADC chip select (active low) and serial clock (idles high)
//     data_ADC    - last captured sample, unsigned, held between frames
//     data_valid  - one-cycle pulse when data_ADC updates
//     busy        - high whenever the FSM is not in IDLE
//     frame_err   - pulses with data_valid if a leading bit was 1
//   Build option: define ADC_LEADZERO_CHECK_EN to enable the leading-zero
//   check; otherwise frame_err is tied low.
module adc_serial_capture
    import adc_serial_capture_pkg::*;
#(
    parameter int unsigned N_ADC      = DEF_N_ADC,
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
    parameter int unsigned DIV        = DEF_DIV,
    parameter int unsigned QUIET_CYC  = DEF_QUIET_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sdata,
    output logic             cs_n,
    output logic             sclk,
    output logic [N_ADC-1:0] data_ADC,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int unsigned BW = cnt_width(FRAME_BITS);
    localparam int unsigned QW = cnt_width(QUIET_CYC);

    state_t                state, state_nxt;
    logic [BW-1:0]         bcnt;
    logic [QW-1:0]         qcnt;
    logic [FRAME_BITS-1:0] sreg;
    logic [FRAME_BITS-1:0] sreg_nxt;
    logic                  sclk_en;
    logic                  rise_tick;
    logic                  last_bit;
    logic                  quiet_done;

    // Register contents after the current rise; lets the final bit land in
    // data_ADC on the same edge it is sampled.
    assign sreg_nxt   = {sreg[FRAME_BITS-2:0], sdata};
    assign last_bit   = rise_tick && (bcnt == BW'(FRAME_BITS - 1));
    assign quiet_done = (qcnt == QW'(QUIET_CYC - 1));

    adc_serial_capture_sclk_divider #(
        .DIV (DIV)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (sclk_en),
        .sclk      (sclk),
        .rise_tick (rise_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = CONV;
            CONV:    if (last_bit)   state_nxt = QUIET;
            QUIET:   if (quiet_done) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so cs_n/busy change on the
    // same edge as the state transition.
    always_comb begin
        cs_n    = (state != CONV);
        busy    = (state != IDLE);
        sclk_en = (state == CONV);
    end

    // Counters, shift register and capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt       <= '0;
            qcnt       <= '0;
            sreg       <= '0;
            data_ADC   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bcnt <= '0;
                    qcnt <= '0;
                end
                CONV: begin
                    if (rise_tick) begin
                        sreg <= sreg_nxt;
                        if (last_bit) begin
                            data_ADC   <= sreg_nxt[N_ADC-1:0];
                            data_valid <= 1'b1;
                            bcnt       <= '0;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                QUIET: begin
                    qcnt <= qcnt + 1'b1;
                end
                default: begin
                    bcnt <= '0;
                    qcnt <= '0;
                end
            endcase
        end
    end

`ifdef ADC_LEADZERO_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= last_bit && (|sreg_nxt[FRAME_BITS-1:N_ADC]);
        end
    end

    // The oldest bit falls off the register without ever being needed.
    logic unused_bits;
    assign unused_bits = sreg[FRAME_BITS-1];
`else
    assign frame_err = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{sreg[FRAME_BITS-1], sreg_nxt[FRAME_BITS-1:N_ADC]};
`endif

endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture
//   Two instances: dut0 (DIV=2, QUIET_CYC=8) and dut1 (DIV=1, QUIET_CYC=8).
//   A frame-level model predicts every output from the cycle offset since
//   the accepted start edge; directed scenarios add literal expectations.
module tb_adc_serial_capture;

    localparam int F = 16;
    localparam int Q = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic sd0 = 1'b0, sd1 = 1'b0;

    logic        cs_n_v [2];
    logic        sclk_v [2];
    logic        dv_v   [2];
    logic        busy_v [2];
    logic        err_v  [2];
    logic [11:0] dadc_v [2];

    int vectors    = 0;
    int miscompares = 0;

    initial forever #5 clk = ~clk;

    adc_serial_capture #(
        .N_ADC(12), .FRAME_BITS(16), .DIV(2), .QUIET_CYC(8)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sdata(sd0),
        .cs_n(cs_n_v[0]), .sclk(sclk_v[0]), .data_ADC(dadc_v[0]),
        .data_valid(dv_v[0]), .busy(busy_v[0]), .frame_err(err_v[0])
    );

    adc_serial_capture #(
        .N_ADC(12), .FRAME_BITS(16), .DIV(1), .QUIET_CYC(8)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sdata(sd1),
        .cs_n(cs_n_v[1]), .sclk(sclk_v[1]), .data_ADC(dadc_v[1]),
        .data_valid(dv_v[1]), .busy(busy_v[1]), .frame_err(err_v[1])
    );

    function automatic int divof(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit [15:0] q0[$];
    bit [15:0] q1[$];
    bit        act_m [2];
    int        j_m   [2];
    bit [15:0] cur_m [2];
    bit [11:0] exp_d [2];

    function automatic bit [15:0] pop_frame(input int i);
        bit [15:0] w;
        w = '0;
        if (i == 0) begin
            if (q0.size() > 0) w = q0.pop_front();
        end else begin
            if (q1.size() > 0) w = q1.pop_front();
        end
        return w;
    endfunction

    // j counts clk edges since the accepted start edge; the frame occupies
    // 2*F*DIV edges, then Q quiet edges, then the block is idle again.
    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                act_m[i] = 1'b0;
                j_m[i]   = 0;
                exp_d[i] = '0;
            end else if (act_m[i]) begin
                j_m[i]++;
                if (j_m[i] == 2 * F * divof(i)) exp_d[i] = cur_m[i][11:0];
                if (j_m[i] == 2 * F * divof(i) + Q) act_m[i] = 1'b0;
            end else if ((i == 0) ? start0 : start1) begin
                act_m[i] = 1'b1;
                j_m[i]   = 0;
                cur_m[i] = pop_frame(i);
            end
        end
    end

    // ---------------- ADC models: next bit out on each sclk fall ----------------
    int idx0 = 0, idx1 = 0;
    initial forever begin
        @(negedge cs_n_v[0] or negedge sclk_v[0]);
        if (sclk_v[0]) begin
            idx0 = 0; sd0 = 1'b0;
        end else if (idx0 < F) begin
            sd0 = cur_m[0][F-1-idx0]; idx0++;
        end
    end
    initial forever begin
        @(negedge cs_n_v[1] or negedge sclk_v[1]);
        if (sclk_v[1]) begin
            idx1 = 0; sd1 = 1'b0;
        end else if (idx1 < F) begin
            sd1 = cur_m[1][F-1-idx1]; idx1++;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int  d, j, fe;
            bit  a, e_cs, e_sclk, e_dv, e_err;
            d  = divof(i);
            j  = j_m[i];
            a  = act_m[i];
            fe = 2 * F * d;
            e_cs   = !(a && j < fe);
            e_sclk = (a && j <= fe) ? (((j / d) % 2) == 0) : 1'b1;
            e_dv   = a && (j == fe);
`ifdef ADC_LEADZERO_CHECK_EN
            e_err  = e_dv && (|cur_m[i][15:12]);
`else
            e_err  = 1'b0;
`endif
            chk($sformatf("cs_n[%0d] j=%0d", i, j), cs_n_v[i], e_cs);
            chk($sformatf("sclk[%0d] j=%0d", i, j), sclk_v[i], e_sclk);
            chk($sformatf("busy[%0d] j=%0d", i, j), busy_v[i], a);
            chk($sformatf("data_valid[%0d] j=%0d", i, j), dv_v[i], e_dv);
            chk($sformatf("frame_err[%0d] j=%0d", i, j), err_v[i], e_err);
            chk($sformatf("data_ADC[%0d] j=%0d", i, j), dadc_v[i], exp_d[i]);
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic run_frame(input int i, input logic [15:0] w,
                             output int lat, output int cslow, output logic err,
                             output logic s2, output logic s3);
        if (i == 0) begin q0.push_back(w); start0 = 1'b1; end
        else        begin q1.push_back(w); start1 = 1'b1; end
        lat = -1; cslow = 0; err = 1'b0; s2 = 1'b0; s3 = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            start0 = 1'b0; start1 = 1'b0;
            if (!cs_n_v[i]) cslow++;
            if (n == 2) s2 = sclk_v[i];
            if (n == 3) s3 = sclk_v[i];
            if (dv_v[i]) begin
                lat = n - 1;
                err = err_v[i];
                break;
            end
        end
    endtask

    initial begin
        int          lat, cslow, nv;
        logic        err, s2, s3, exp_err;
        logic [11:0] vals [3];
        int          tv   [3];

        repeat (3) @(negedge clk);
        chk("reset cs_n", cs_n_v[0], 1);
        chk("reset sclk", sclk_v[0], 1);
        chk("reset busy", busy_v[0], 0);
        chk("reset data_ADC", dadc_v[0], 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame
        run_frame(0, 16'h0ABC, lat, cslow, err, s2, s3);
        chk("basic latency", lat, 64);
        chk("basic data", dadc_v[0], 12'hABC);
        chk("basic cs_n low cycles", cslow, 64);
        repeat (12) @(negedge clk);
        chk("basic data held", dadc_v[0], 12'hABC);

        // Start pulses during CONV and QUIET are ignored
        q0.push_back(16'h0123);
        start0 = 1'b1; nv = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start0 = (n == 10 || n == 68);
            if (dv_v[0]) nv++;
            if (n == 11) chk("busy after CONV start", busy_v[0], 1);
            if (n == 69) chk("busy after QUIET start", busy_v[0], 1);
        end
        chk("ignored start single valid", nv, 1);
        chk("ignored start data", dadc_v[0], 12'h123);

        // Back-to-back with start held high
        q0.push_back(16'h0000); q0.push_back(16'h0FFF); q0.push_back(16'h0801);
        start0 = 1'b1; nv = 0;
        foreach (tv[k]) begin tv[k] = 0; vals[k] = 'x; end
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (dv_v[0]) begin
                vals[nv] = dadc_v[0];
                tv[nv]   = n;
                nv++;
                if (nv == 3) begin start0 = 1'b0; break; end
            end
        end
        start0 = 1'b0;
        chk("b2b pulse count", nv, 3);
        chk("b2b first latency", tv[0] - 1, 64);
        chk("b2b spacing 1", tv[1] - tv[0], 73);
        chk("b2b spacing 2", tv[2] - tv[1], 73);
        chk("b2b value 0", vals[0], 12'h000);
        chk("b2b value 1", vals[1], 12'hFFF);
        chk("b2b value 2", vals[2], 12'h801);
        repeat (20) @(negedge clk);

        // Reset mid-frame
        q0.push_back(16'h0555);
        start0 = 1'b1; nv = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (dv_v[0]) nv++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midreset cs_n", cs_n_v[0], 1);
        chk("midreset sclk", sclk_v[0], 1);
        chk("midreset busy", busy_v[0], 0);
        chk("midreset data_ADC", dadc_v[0], 0);
        repeat (2) @(negedge clk);
        if (dv_v[0]) nv++;
        rst_n = 1'b1;
        chk("midreset no valid", nv, 0);
        repeat (2) @(negedge clk);
        run_frame(0, 16'h0A5A, lat, cslow, err, s2, s3);
        chk("post-reset latency", lat, 64);
        chk("post-reset data", dadc_v[0], 12'hA5A);
        repeat (12) @(negedge clk);

        // Leading-bit error frame
`ifdef ADC_LEADZERO_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_frame(0, 16'h4123, lat, cslow, err, s2, s3);
        chk("leadbit latency", lat, 64);
        chk("leadbit data", dadc_v[0], 12'h123);
        chk("leadbit frame_err", err, exp_err);
        repeat (12) @(negedge clk);

        // DIV=1 corner
        run_frame(1, 16'h0001, lat, cslow, err, s2, s3);
        chk("div1 latency", lat, 32);
        chk("div1 data", dadc_v[1], 12'h001);
        chk("div1 cs_n low cycles", cslow, 32);
        chk("div1 sclk low after E0+1", s2, 0);
        chk("div1 sclk high after E0+2", s3, 1);
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
